booth_mul_ctrl: RTL and testbench

- Multi-cycle signed 32x32 multiplier controller that sequences the shared 32-bit carry-lookahead FastAdder to form a 64-bit product in HI/LO.
- Uses radix-2 Booth recoding: one add/subtract/no-op plus one arithmetic right shift per cycle, 32 iterations.
- The adder is instantiated beside this block in the ALU. The controller drives its operands and carry-in, and consumes its sum and carry-out combinationally in the same cycle.
- Sits between the ALU operand registers (RY/RB) and the HI/LO register load path.

---
 rtl/booth_mul_ctrl.sv | 69 ++++++
 tb/tb_booth_mul_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: radix-2 Booth sequencer driving a shared external adder; 32 add/sub+shift steps form a signed 64-bit product.
module booth_mul_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] add_x,
    output logic [WIDTH-1:0] add_y,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a, q, m, a_new;
    logic [CNT_W-1:0] cnt;
    logic q_1, s, run, do_add, do_sub, last;

    always_comb begin
        run      = state == RUN;
        do_add   = run && {q[0], q_1} == 2'b01;
        do_sub   = run && {q[0], q_1} == 2'b10;
        add_x    = run ? a : '0;
        add_y    = do_add ? m : do_sub ? ~m : '0;
        add_cin  = do_sub;
        a_new    = (do_add || do_sub) ? add_sum : a;
        // 33rd result bit recovered from the carry so M = most-negative stays exact
        s        = (do_add || do_sub) ? a[WIDTH-1] ^ add_y[WIDTH-1] ^ add_cout : a[WIDTH-1];
        last     = cnt == CNT_W'(WIDTH - 1);
        state_nx = run ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    assign busy = run;
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state  <= IDLE;
            a      <= '0;
            q      <= '0;
            m      <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            state <= state_nx;
            if (!run && start) begin
                m   <= multiplicand;
                q   <= multiplier;
                a   <= '0;
                q_1 <= 1'b0;
                cnt <= '0;
            end else if (run) begin
                {a, q, q_1} <= {s, a_new, q};
                cnt         <= cnt + 1'b1;
                if (last) {hi_out, lo_out} <= {s, a_new, q[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl: directed and randomised checks of the Booth controller with a behavioural adder beside it.
module tb_booth_mul_ctrl;
    logic        clk = 1'b0;
    logic        nRst, start;
    logic [31:0] multiplicand, multiplier, add_x, add_y, add_sum, hi_out, lo_out;
    logic        add_cin, add_cout, busy, done;
    int          checks = 0;
    int          errors = 0;

    booth_mul_ctrl dut (
        .clk(clk), .nRst(nRst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    assign {add_cout, add_sum} = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};

    always #5 clk = ~clk;

    task automatic run_mul(input logic [31:0] mv, input logic [31:0] qv,
                           output logic [31:0] h, output logic [31:0] l,
                           output int bc, output logic dn);
        @(negedge clk);
        start = 1'b1; multiplicand = mv; multiplier = qv;
        @(negedge clk);
        start = 1'b0; multiplicand = $urandom; multiplier = $urandom;
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        dn = done; h = hi_out; l = lo_out;
    endtask

    task automatic test_reset;
        nRst = 1'b0; start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9;
        repeat (3) @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {busy, done}); end
        checks++; if ({hi_out, lo_out} !== 64'd0) begin errors++; $display("FAIL reset_prod got %h want 0", {hi_out, lo_out}); end
        checks++; if ({add_x, add_y, add_cin} !== 65'd0) begin errors++; $display("FAIL reset_bus got %h %h %b want 0", add_x, add_y, add_cin); end
        nRst = 1'b1;
    endtask

    task automatic test_basic;
        logic [31:0] h, l; int bc; logic dn;
        run_mul(32'd3, 32'd5, h, l, bc, dn);
        checks++; if (bc !== 32) begin errors++; $display("FAIL basic_busy got %0d want 32", bc); end
        checks++; if (dn !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", dn); end
        checks++; if ({h, l} !== 64'h00000000_0000000F) begin errors++; $display("FAIL basic_prod got %h%h want 000000000000000f", h, l); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL basic_pulse got %b want 00", {busy, done}); end
        checks++; if ({add_x, add_y, add_cin} !== 65'd0) begin errors++; $display("FAIL idle_bus got %h %h %b want 0", add_x, add_y, add_cin); end
        checks++; if ({hi_out, lo_out} !== 64'h0000000F) begin errors++; $display("FAIL hold_prod got %h%h want f", hi_out, lo_out); end
    endtask

    task automatic test_mixed;
        logic [31:0] h, l; int bc; logic dn;
        run_mul(32'hFFFFFFFD, 32'd5, h, l, bc, dn);
        checks++; if ({dn, h, l} !== {1'b1, 64'hFFFFFFFF_FFFFFFF1}) begin errors++; $display("FAIL mixed_a got %b %h%h want 1 fffffffffffffff1", dn, h, l); end
        run_mul(32'd5, 32'hFFFFFFFD, h, l, bc, dn);
        checks++; if ({dn, h, l} !== {1'b1, 64'hFFFFFFFF_FFFFFFF1}) begin errors++; $display("FAIL mixed_b got %b %h%h want 1 fffffffffffffff1", dn, h, l); end
    endtask

    task automatic test_most_negative;
        logic [31:0] h, l; int bc; logic dn;
        run_mul(32'h80000000, 32'h80000000, h, l, bc, dn);
        checks++; if ({h, l} !== 64'h40000000_00000000) begin errors++; $display("FAIL minmin got %h%h want 4000000000000000", h, l); end
        run_mul(32'h80000000, 32'hFFFFFFFF, h, l, bc, dn);
        checks++; if ({h, l} !== 64'h00000000_80000000) begin errors++; $display("FAIL minneg1 got %h%h want 0000000080000000", h, l); end
    endtask

    task automatic test_adder_bus;
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd5; multiplier = 32'd1;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({add_x, add_y, add_cin} !== {32'd0, 32'hFFFFFFFA, 1'b1}) begin errors++; $display("FAIL sub_bus got %h %h %b want 0 fffffffa 1", add_x, add_y, add_cin); end
        @(negedge clk);
        checks++; if ({add_y, add_cin} !== {32'd5, 1'b0}) begin errors++; $display("FAIL add_bus got %h %b want 5 0", add_y, add_cin); end
        @(negedge clk);
        checks++; if ({add_y, add_cin} !== 33'd0) begin errors++; $display("FAIL nop_bus got %h %b want 0 0", add_y, add_cin); end
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        checks++; if ({done, hi_out, lo_out} !== {1'b1, 64'd5}) begin errors++; $display("FAIL bus_prod got %b %h%h want 1 5", done, hi_out, lo_out); end
    endtask

    task automatic test_start_ignored;
        int bc;
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd3; multiplier = 32'd5;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            start = (bc == 10); multiplicand = 32'd7; multiplier = 32'd9;
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (bc !== 32) begin errors++; $display("FAIL ign_busy got %0d want 32", bc); end
        checks++; if ({done, hi_out, lo_out} !== {1'b1, 64'd15}) begin errors++; $display("FAIL ign_prod got %b %h%h want 1 f", done, hi_out, lo_out); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h, l; int bc; logic dn;
        run_mul(32'd2, 32'd3, h, l, bc, dn);
        checks++; if ({dn, h, l} !== {1'b1, 64'd6}) begin errors++; $display("FAIL b2b_first got %b %h%h want 1 6", dn, h, l); end
        start = 1'b1; multiplicand = 32'd4; multiplier = 32'd5;
        @(negedge clk);
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_restart got %b want 10", {busy, done}); end
        bc = 0;
        while (busy === 1'b1 && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        checks++; if (bc !== 32) begin errors++; $display("FAIL b2b_busy got %0d want 32", bc); end
        checks++; if ({done, hi_out, lo_out} !== {1'b1, 64'd20}) begin errors++; $display("FAIL b2b_prod got %b %h%h want 1 14", done, hi_out, lo_out); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] h, l; int bc; logic dn; logic seen;
        @(negedge clk);
        start = 1'b1; multiplicand = 32'd3; multiplier = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        checks++; if ({busy, done, hi_out, lo_out} !== 66'd0) begin errors++; $display("FAIL midrst got %b%b %h%h want 0", busy, done, hi_out, lo_out); end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= done | busy;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_quiet got %b want 0", seen); end
        run_mul(32'd7, 32'hFFFFFFFA, h, l, bc, dn);
        checks++; if ({dn, h, l} !== {1'b1, 64'hFFFFFFFF_FFFFFFD6}) begin errors++; $display("FAIL post_rst got %b %h%h want 1 ffffffffffffffd6", dn, h, l); end
    endtask

    task automatic test_random;
        logic [31:0] h, l, mv, qv; int bc; logic dn; logic [63:0] ref_p;
        for (int i = 0; i < 300; i++) begin
            mv = $urandom; qv = $urandom;
            ref_p = 64'(longint'($signed(mv)) * longint'($signed(qv)));
            run_mul(mv, qv, h, l, bc, dn);
            checks++;
            if ({dn, h, l} !== {1'b1, ref_p}) begin
                errors++;
                $display("FAIL rand %h*%h got %b %h%h want 1 %h", mv, qv, dn, h, l, ref_p);
            end
        end
    endtask

    initial begin
        nRst = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
        test_reset;
        test_basic;
        test_mixed;
        test_most_negative;
        test_adder_bus;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
